// File: rtl/hotone_pkg.sv
// Shared constants, types and the one-hot decode helper for the class decoder.
package hotone_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int IDX_W       = 4;
  localparam int CNT_W_DEF   = 16;

  typedef logic [IDX_W-1:0] class_idx_t;

  localparam class_idx_t ERR_IDX = 4'hF;

  typedef struct packed {
    logic       err;
    class_idx_t idx;
  } dec_res_t;

  // Bit NUM_CLASSES-1 is class 0. Anything other than exactly one set bit is
  // flagged as an error; multi-hot vectors are never priority-resolved.
  function automatic dec_res_t decode_onehot(input logic [NUM_CLASSES-1:0] vec);
    int unsigned ones;
    class_idx_t  idx;
    dec_res_t    res;
    ones = 0;
    idx  = ERR_IDX;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (vec[NUM_CLASSES-1-i]) begin
        ones = ones + 1;
        idx  = class_idx_t'(i);
      end
    end
    if (ones == 1) begin
      res.err = 1'b0;
      res.idx = idx;
    end else begin
      res.err = 1'b1;
      res.idx = ERR_IDX;
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clear has priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hotone_decoder.sv
// Two-stage one-hot class decoder with per-class, total and error statistics.
module hotone_decoder
  import hotone_pkg::class_idx_t;
  import hotone_pkg::dec_res_t;
  import hotone_pkg::decode_onehot;
  import hotone_pkg::CNT_W_DEF;
#(
  parameter int NUM_CLASSES = hotone_pkg::NUM_CLASSES,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   input_valid,
  input  logic [NUM_CLASSES-1:0] d_in,
  output logic                   output_valid,
  output logic [3:0]             d_out,
  output logic                   err,
  input  logic                   cnt_clear,
  input  logic [3:0]             rd_sel,
  output logic [CNT_W-1:0]       rd_cnt,
  output logic [CNT_W-1:0]       total_cnt,
  output logic [CNT_W-1:0]       err_cnt
);

  logic                   s1_valid;
  logic [NUM_CLASSES-1:0] s1_data;
  dec_res_t               s1_dec;

  assign s1_dec = decode_onehot(s1_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_data      <= '0;
      output_valid <= 1'b0;
      d_out        <= '0;
      err          <= 1'b0;
    end else begin
      s1_valid     <= input_valid;
      s1_data      <= d_in;
      output_valid <= s1_valid;
      // d_out/err hold their last result while no new result is delivered
      if (s1_valid) begin
        d_out <= s1_dec.idx;
        err   <= s1_dec.err;
      end
    end
  end

  // Statistics are driven from the registered result, so they trail
  // output_valid by one edge.
  logic [NUM_CLASSES-1:0] cls_inc;
  logic [CNT_W-1:0]       class_cnt [NUM_CLASSES];

  always_comb begin
    cls_inc = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      cls_inc[i] = output_valid && !err && (d_out == class_idx_t'(i));
    end
  end

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_cls
    sat_counter #(.W(CNT_W)) u_cls_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cls_inc[g]),
      .clr   (cnt_clear),
      .cnt   (class_cnt[g])
    );
  end

  sat_counter #(.W(CNT_W)) u_total_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (output_valid),
    .clr   (cnt_clear),
    .cnt   (total_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (output_valid & err),
    .clr   (cnt_clear),
    .cnt   (err_cnt)
  );

  // Unmapped selects (10..15) read as zero.
  logic [CNT_W-1:0] rd_next;

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (rd_sel == class_idx_t'(i)) begin
        rd_next = class_cnt[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= '0;
    end else begin
      rd_cnt <= rd_next;
    end
  end

endmodule
